sa_seq_ctrl: RTL

SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

---
 rtl/sa_pkg.sv | 15 +
 rtl/sa_seq_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state encoding and default timing for the systolic-array sequencer
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_SETTLE = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4
  } sa_state_t;

  localparam int DEF_ROWS   = 32;
  localparam int DEF_SETTLE = 2;

endpackage

// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - per-tile weight preload / settle / data sequencing for a systolic array
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int LAYER_W = 2,
  parameter int TILE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_i,
  input  logic [TILE_W-1:0]  num_tiles_i,
  input  logic               d_valid_i,
  input  logic               data_last,
  input  logic               abort,
  output logic               data_enable,
  output logic               weight_start,
  output logic               weight_stop,
  output logic [LAYER_W-1:0] layer_o,
  output logic [TILE_W-1:0]  tile_idx_o,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(ROWS + SETTLE + 1);
  localparam logic [CNT_W-1:0] WLOAD_END  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  sa_state_t          state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TILE_W-1:0]  last_tile, last_tile_n, tile_n;
  logic [LAYER_W-1:0] layer_n;
  logic               data_enable_n, weight_start_n, weight_stop_n, busy_n, done_n;

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    tile_n      = tile_idx_o;
    layer_n     = layer_o;
    last_tile_n = last_tile;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_n     = S_WLOAD;
          layer_n     = layer_i;
          tile_n      = '0;
          // a zero tile count runs a single tile; storing count-1 keeps 2^TILE_W-1 in range
          last_tile_n = (num_tiles_i == '0) ? '0 : num_tiles_i - TILE_W'(1);
        end
      end
      S_WLOAD:  if (cnt == WLOAD_END) state_n = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_END) state_n = S_DATA;
      S_DATA: begin
        if (d_valid_i && data_last) begin
          if (tile_idx_o == last_tile) begin
            state_n = S_DONE;
          end else begin
            state_n = S_WLOAD;
            tile_n  = tile_idx_o + TILE_W'(1);
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      tile_n  = '0;
      layer_n = '0;
    end
    if (state_n != state) cnt_n = '0;

    // outputs are decoded from the upcoming state so they register alongside it
    data_enable_n  = (state_n == S_DATA);
    weight_start_n = (state_n == S_WLOAD);
    weight_stop_n  = (state_n == S_DATA) || (state_n == S_IDLE) || (state_n == S_DONE);
    busy_n         = (state_n != S_IDLE);
    done_n         = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_tile    <= '0;
      tile_idx_o   <= '0;
      layer_o      <= '0;
      data_enable  <= 1'b0;
      weight_start <= 1'b0;
      weight_stop  <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_tile    <= last_tile_n;
      tile_idx_o   <= tile_n;
      layer_o      <= layer_n;
      data_enable  <= data_enable_n;
      weight_start <= weight_start_n;
      weight_stop  <= weight_stop_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule
